// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed scan controller for a multi-digit common-anode 7-segment
//   display.  One shared BCD-to-7-segment converter is fed a nibble per digit
//   slot through bcd_sel, while the active-low anode enables step in lockstep.
//   Each digit slot is a short all-dark BLANK phase (anti-ghosting) followed by
//   a SHOW phase.  Processor writes land in a shadow register and are applied
//   only at a frame boundary, so a frame never mixes old and new digits.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN
//     defined   -> digits above the most significant nonzero digit are driven
//                  as blank (4'hF); digit 0 is always shown.
//     undefined -> every digit is shown as stored.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | scanning disabled, all anodes off, counter and digit cleared
//   BLANK | leading part of a digit slot, all anodes off
//   SHOW  | current digit's anode on, its nibble driven on bcd_sel
module seg7_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [3:0]              bcd_sel,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [DIG_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - BLANK_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [3:0]       NIB_BLANK  = 4'hF;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [4*NUM_DIGITS-1:0] display_q, display_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              bcd_sel_q, bcd_sel_d;
  logic                    frame_done_q, frame_done_d;

  logic                    frame_end;
  logic [3:0]              nib_sel;
  logic                    digit_shown;

  // Last SHOW cycle of the last digit: the frame boundary for shadow transfer.
  assign frame_end = (state_q == ST_SHOW) && (digit_q == DIG_LAST) && (cnt_q == SHOW_LAST);

  // Scan sequencing: slot phase, phase counter and current digit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      digit_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          digit_d = '0;
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + DIG_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          digit_d = '0;
        end
      endcase
    end
  end

  // Shadow handling: direct writes when idle, deferred writes while scanning.
  always_comb begin
    display_d       = display_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (state_q == ST_IDLE) begin
      // Nothing is on screen, so there is nothing to tear; leftover pending
      // data from before a disable is flushed here as well.
      if (load) begin
        display_d       = value_in;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        display_d       = pending_q;
        pending_valid_d = 1'b0;
      end
    end else if (frame_end) begin
      // A load landing exactly on the boundary is newer than anything pending.
      pending_valid_d = 1'b0;
      if (load) begin
        display_d = value_in;
      end else if (pending_valid_q) begin
        display_d = pending_q;
      end
    end else if (load) begin
      pending_d       = value_in;
      pending_valid_d = 1'b1;
    end
  end

  // Nibble of the digit that will occupy the next cycle's slot.
  always_comb begin
    nib_sel = NIB_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_d == DIG_W'(i)) begin
        nib_sel = display_q[4*i +: 4];
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIG_W-1:0] msd_idx;

  // Index of the most significant nonzero digit; 0 when the value is zero.
  always_comb begin
    msd_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (display_q[4*i +: 4] != 4'h0) begin
        msd_idx = DIG_W'(i);
      end
    end
  end

  assign digit_shown = (digit_d <= msd_idx);
`else
  assign digit_shown = 1'b1;
`endif

  // Registered display outputs, computed from the next state so they line up with it.
  always_comb begin
    an_n_d       = '1;
    bcd_sel_d    = NIB_BLANK;
    frame_done_d = 1'b0;
    if (state_d == ST_SHOW) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_n_d[i] = (digit_d != DIG_W'(i));
      end
      bcd_sel_d    = digit_shown ? nib_sel : NIB_BLANK;
      frame_done_d = (digit_d == DIG_LAST) && (cnt_d == SHOW_LAST);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      digit_q         <= '0;
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      an_n_q          <= '1;
      bcd_sel_q       <= NIB_BLANK;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      digit_q         <= digit_d;
      display_q       <= display_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      an_n_q          <= an_n_d;
      bcd_sel_q       <= bcd_sel_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign an_n       = an_n_q;
  assign bcd_sel    = bcd_sel_q;
  assign digit_idx  = digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// Directed bench for seg7_scan_controller (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2).
module tb_seg7_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0000;
  logic [3:0]  bcd_sel;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [3:0] LZ = 4'hF;
`else
  localparam logic [3:0] LZ = 4'h0;
`endif

  seg7_scan_controller #(
    .NUM_DIGITS  (4),
    .CLK_DIV     (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .load      (load),
    .value_in  (value_in),
    .bcd_sel   (bcd_sel),
    .an_n      (an_n),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, ".an_n"}, 32'(an_n), 32'hF);
    check({tag, ".bcd_sel"}, 32'(bcd_sel), 32'hF);
    check({tag, ".frame_done"}, 32'(frame_done), 32'h0);
    check({tag, ".digit_idx"}, 32'(digit_idx), 32'h0);
  endtask

  // Checks ncyc cycles of digit slot d showing nibble nib; optionally pulses
  // load with load_val after the checks of cycle load_at.
  task automatic check_slot(input int d, input logic [3:0] nib, input int ncyc,
                            input int load_at, input logic [15:0] load_val);
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [3:0] exp_bcd;
    logic       exp_fd;
    one = 4'b0001;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      load = 1'b0;
      exp_an  = (c < 2) ? 4'hF : ~(one << d);
      exp_bcd = (c < 2) ? 4'hF : nib;
      exp_fd  = (d == 3) && (c == 7);
      check($sformatf("slot%0d.c%0d.an_n", d, c), 32'(an_n), 32'(exp_an));
      check($sformatf("slot%0d.c%0d.bcd_sel", d, c), 32'(bcd_sel), 32'(exp_bcd));
      check($sformatf("slot%0d.c%0d.frame_done", d, c), 32'(frame_done), 32'(exp_fd));
      check($sformatf("slot%0d.c%0d.digit_idx", d, c), 32'(digit_idx), 32'(d));
      if (c == load_at) begin
        load     = 1'b1;
        value_in = load_val;
      end
    end
  endtask

  task automatic check_frame(input logic [15:0] v);
    check_slot(0, v[3:0],   8, -1, 16'h0);
    check_slot(1, v[7:4],   8, -1, 16'h0);
    check_slot(2, v[11:8],  8, -1, 16'h0);
    check_slot(3, v[15:12], 8, -1, 16'h0);
  endtask

  initial begin
    // Asynchronous reset takes effect without a clock edge.
    #1 rst_n = 1'b0;
    #1 check_dark("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_dark("idle_after_reset");

    // Load while idle, then start scanning.
    load = 1'b1; value_in = 16'h1234;
    @(negedge clk);
    load = 1'b0;
    check_dark("idle_after_load");
    enable = 1'b1;
    check_frame(16'h1234);

    // Load during digit 1 SHOW: the current frame keeps the old value.
    check_slot(0, 4'h4, 8, -1, 16'h0);
    check_slot(1, 4'h3, 8, 4, 16'h5678);
    check_slot(2, 4'h2, 8, -1, 16'h0);
    check_slot(3, 4'h1, 8, -1, 16'h0);

    // New frame shows the shadowed value; a pending load is then overtaken
    // by a load coincident with frame_done.
    check_slot(0, 4'h8, 8, -1, 16'h0);
    check_slot(1, 4'h7, 8, -1, 16'h0);
    check_slot(2, 4'h6, 8, 3, 16'h9999);
    check_slot(3, 4'h5, 8, 7, 16'h4321);
    check_frame(16'h4321);
    check_frame(16'h4321);

    // Disable in the middle of digit 2 SHOW.
    check_slot(0, 4'h1, 8, -1, 16'h0);
    check_slot(1, 4'h2, 8, -1, 16'h0);
    check_slot(2, 4'h3, 4, -1, 16'h0);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_dark($sformatf("disabled%0d", i));
    end

    // Re-enable restarts at BLANK of digit 0.
    enable = 1'b1;
    check_slot(0, 4'h1, 8, -1, 16'h0);
    check_slot(1, 4'h2, 5, -1, 16'h0);

    // Asynchronous reset mid-SHOW.
    #2 rst_n = 1'b0;
    enable = 1'b0;
    #1 check_dark("reset_mid_show");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_dark("idle_after_reset2");

    // Leading-zero handling, then non-BCD nibbles pass through unchanged.
    load = 1'b1; value_in = 16'h0070;
    @(negedge clk);
    load = 1'b0;
    enable = 1'b1;
    check_slot(0, 4'h0, 8, -1, 16'h0);
    check_slot(1, 4'h7, 8, -1, 16'h0);
    check_slot(2, LZ,   8, -1, 16'h0);
    check_slot(3, LZ,   8, 3, 16'hFEA3);
    check_frame(16'hFEA3);

    load = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    check_dark("final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
